// File: rtl/key16_scan.sv
// 4x4 keypad scanner: drives one column at a time, debounces every key and
// queues press/release events in a 4-deep FIFO.
module key16_scan #(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned DB_N       = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  col_oe,
    input  logic [3:0]  row_n,
    output logic [15:0] keybits,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [4:0]  ev_code,
    output logic        overflow
);
    localparam int unsigned DBW         = $clog2(DB_N + 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [DBW:0] DB_MAX     = (DBW + 1)'(DB_N);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_SAMPLE,
        ST_EMIT
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] col_q, col_d;
    logic       run_q;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] sample_q, sample_d;
    logic       emit;

    // Idle rows read high through the pull-ups, so the synchronizer resets to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= row_n;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // sees the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            col_q    <= '0;
            run_q    <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            run_q    <= 1'b1;
            sample_q <= sample_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        sample_d = sample_q;
        emit     = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                // The first cycle out of reset only starts driving column 0.
                if (run_q) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_SAMPLE: begin
                sample_d = ~sync2_q;
                state_d  = ST_EMIT;
                cnt_d    = '0;
            end
            ST_EMIT: begin
                emit = 1'b1;
                if (cnt_q == 8'd3) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign col_oe = run_q ? (4'b0001 << col_q) : 4'b0000;

    logic [15:0]    keybits_q, keybits_d;
    logic [DBW-1:0] db_cnt_q [16];
    logic [DBW-1:0] db_cnt_d;
    logic [DBW:0]   db_inc;
    logic [3:0]     key_idx;
    logic           key_cur, key_smp, toggle;

    // One key is debounced per EMIT cycle: key 4*column + row.
    always_comb begin
        key_idx   = {col_q, cnt_q[1:0]};
        key_cur   = keybits_q[key_idx];
        key_smp   = sample_q[cnt_q[1:0]];
        db_inc    = {1'b0, db_cnt_q[key_idx]} + (DBW + 1)'(1);
        db_cnt_d  = db_cnt_q[key_idx];
        keybits_d = keybits_q;
        toggle    = 1'b0;
        if (emit) begin
            if (key_smp == key_cur) begin
                db_cnt_d = '0;
            end else if (db_inc == DB_MAX) begin
                db_cnt_d           = '0;
                toggle             = 1'b1;
                keybits_d[key_idx] = ~key_cur;
            end else begin
                db_cnt_d = db_inc[DBW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            keybits_q <= '0;
            for (int i = 0; i < 16; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            keybits_q <= keybits_d;
            if (emit) begin
                db_cnt_q[key_idx] <= db_cnt_d;
            end
        end
    end

    assign keybits = keybits_q;

    logic [4:0] fifo_mem [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] count_q;
    logic       overflow_q;
    logic       full, pop, do_push;

    assign full    = (count_q == 3'd4);
    assign pop     = (count_q != 3'd0) && ev_ready;
    assign do_push = toggle && (!full || pop);

    // NOTE: the storage array is not reset; emptiness is tracked by count_q
    // and the head output is forced to zero when nothing is queued.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_q] <= {~key_cur, key_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 2'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 2'd1;
            end
            case ({do_push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            if (toggle && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign ev_valid = (count_q != 3'd0);
    assign ev_code  = ev_valid ? fifo_mem[rd_q] : 5'd0;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key16_scan.sv
// Directed bench for key16_scan: a keypad model closes rows on driven columns,
// and logged events are compared with hand-computed codes and clock edges.
module tb_key16_scan;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  col_oe;
    logic [3:0]  row_n;
    logic [15:0] keybits;
    logic        ev_valid;
    logic        ev_ready;
    logic [4:0]  ev_code;
    logic        overflow;
    logic [15:0] keys;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned ecnt = 0;
    int unsigned key9_hits = 0;

    typedef struct {
        logic [4:0]  code;
        int unsigned edge_n;
        logic [3:0]  oe;
    } ev_t;
    ev_t evq[$];

    key16_scan #(.SETTLE_CYC(16), .DB_N(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .col_oe   (col_oe),
        .row_n    (row_n),
        .keybits  (keybits),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // A closed key pulls its row low while its column is driven.
    function automatic logic [3:0] pad(input logic [3:0] oe, input logic [15:0] k);
        logic [3:0] r;
        r = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++)
                if (oe[c] && k[4*c+i]) r[i] = 1'b0;
        return r;
    endfunction

    assign row_n = pad(col_oe, keys);

    // ecnt = number of rising edges since the last edge with reset high.
    always @(posedge clk) begin
        if (reset) ecnt = 0;
        else       ecnt = ecnt + 1;
    end

    always @(negedge clk) begin
        ev_t e;
        #1;
        if (!reset && ev_valid && ev_ready) begin
            e.code   = ev_code;
            e.edge_n = ecnt;
            e.oe     = col_oe;
            evq.push_back(e);
        end
        if (keybits[9]) key9_hits++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_to(input int unsigned target);
        int guard = 0;
        while (ecnt < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (ecnt < target) check("run_to timeout", ecnt, target);
    endtask

    task automatic check_seq(input string tag, input int base, input int n,
                             input logic [4:0] code0, input int unsigned edge0,
                             input bit chk_edge);
        check({tag, " count"}, evq.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < evq.size()) begin
                check($sformatf("%s code%0d", tag, i), evq[base+i].code, code0 + 5'(i));
                if (chk_edge)
                    check($sformatf("%s edge%0d", tag, i), evq[base+i].edge_n, edge0 + i);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        reset    = 1'b1;
        ev_ready = 1'b1;
        keys     = '0;
        repeat (3) @(negedge clk);
        check("rst col_oe", col_oe, 4'b0000);
        check("rst keybits", keybits, 16'h0000);
        check("rst ev_valid", ev_valid, 1'b0);
        check("rst ev_code", ev_code, 5'h00);
        check("rst overflow", overflow, 1'b0);

        // Key 6 (column 1, row 2) held from the start: press event in scan 2.
        keys  = 16'h0040;
        reset = 1'b0;
        @(negedge clk);
        check("col_oe first", col_oe, 4'b0001);
        run_to(21);
        check("col0 last", col_oe, 4'b0001);
        run_to(22);
        check("col1 first", col_oe, 4'b0010);
        run_to(84);
        check("col3 last", col_oe, 4'b1000);
        run_to(85);
        check("col wrap", col_oe, 4'b0001);
        run_to(260);
        check_seq("press6", 0, 1, 5'h16, 210, 1'b1);
        if (evq.size() > 0) check("press6 col_oe", evq[0].oe, 4'b0010);
        check("press6 keybits", keybits, 16'h0040);

        // Release key 6: release event three scans later.
        base = evq.size();
        keys = 16'h0000;
        run_to(520);
        check_seq("release6", base, 1, 5'h06, 462, 1'b1);
        check("release6 keybits", keybits, 16'h0000);

        // Key 9 seen in only two scans: filtered out.
        base = evq.size();
        key9_hits = 0;
        keys = 16'h0200;
        run_to(690);
        keys = 16'h0000;
        run_to(942);
        check("bounce9 events", evq.size() - base, 0);
        check("bounce9 key9 seen", key9_hits, 0);
        check("bounce9 keybits", keybits, 16'h0000);

        // Whole column 1 pressed: four events on consecutive cycles.
        base = evq.size();
        keys = 16'h00F0;
        run_to(1190);
        check_seq("col1 press", base, 4, 5'h14, 1132, 1'b1);
        check("col1 keybits", keybits, 16'h00F0);
        base = evq.size();
        keys = 16'h0000;
        run_to(1440);
        check_seq("col1 release", base, 4, 5'h04, 1384, 1'b1);
        check("col1 rel keybits", keybits, 16'h0000);

        // Consumer stalled: FIFO fills with 0x10..0x13, key 8 event dropped.
        base = evq.size();
        ev_ready = 1'b0;
        keys = 16'h010F;
        run_to(1700);
        check("stall events", evq.size() - base, 0);
        check("stall ev_valid", ev_valid, 1'b1);
        check("stall ev_code", ev_code, 5'h10);
        check("stall overflow", overflow, 1'b1);
        check("stall keybits", keybits, 16'h010F);
        ev_ready = 1'b1;
        run_to(1708);
        check_seq("drain", base, 4, 5'h10, 0, 1'b0);
        check("drain ev_valid", ev_valid, 1'b0);
        check("drain overflow sticky", overflow, 1'b1);

        // Overflow clears only through reset.
        reset = 1'b1;
        @(negedge clk);
        check("rst2 overflow", overflow, 1'b0);
        check("rst2 keybits", keybits, 16'h0000);
        keys = 16'h0003;
        ev_ready = 1'b0;
        reset = 1'b0;

        // Two events queued, then reset in column-2 SETTLE discards them.
        run_to(215);
        check("pend ev_valid", ev_valid, 1'b1);
        check("pend ev_code", ev_code, 5'h10);
        check("pend keybits", keybits, 16'h0003);
        check("pend col_oe", col_oe, 4'b0100);
        reset = 1'b1;
        @(negedge clk);
        check("abort col_oe", col_oe, 4'b0000);
        check("abort keybits", keybits, 16'h0000);
        check("abort ev_valid", ev_valid, 1'b0);
        check("abort ev_code", ev_code, 5'h00);
        check("abort overflow", overflow, 1'b0);
        keys = 16'h0000;
        ev_ready = 1'b1;
        reset = 1'b0;
        base = evq.size();
        @(negedge clk);
        check("abort col_oe restart", col_oe, 4'b0001);
        run_to(200);
        check("abort no events", evq.size() - base, 0);
        check("abort ev_valid late", ev_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/key16_scan.md
KEY16_SCAN -- requirements
Module: key16_scan

Interface
REQ-001 Parameter SETTLE_CYC, default 16: cycles each column is driven before its rows are sampled; legal range 3..255.
REQ-002 Parameter DB_N, default 3: consecutive differing samples required to flip a debounced key; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 col_oe  output  4  tri-state enables for column pins; pad value tied 0; one-hot, 1 = column driven low.
REQ-006 row_n  input  4  row pins, external pull-ups, active-low (0 = key closed on driven column).
REQ-007 keybits  output  16  debounced key state, bit k = 4*column + row, 1 = pressed.
REQ-008 ev_valid  output  1  event FIFO non-empty.
REQ-009 ev_ready  input  1  consumer accepts head event when ev_valid=1.
REQ-010 ev_code  output  5  head event: bit4 = 1 press / 0 release, bits3:0 = key index k.
REQ-011 overflow  output  1  sticky: an event was dropped because the FIFO was full.

Function
REQ-012 row_n passes through a 2-flop synchronizer before use; raw pressed = ~synchronized row_n.
REQ-013 Scan FSM states SETTLE, SAMPLE, EMIT; column index c (2 bits) selects col_oe = one-hot(c), held for the whole column period.
REQ-014 SETTLE lasts exactly SETTLE_CYC cycles, then SAMPLE 1 cycle, then EMIT 4 cycles (rows 0..3 in ascending order, one per cycle), then c increments (3 wraps to 0) and FSM enters SETTLE.
REQ-015 Column period = SETTLE_CYC+5 cycles; full scan = 4*(SETTLE_CYC+5) cycles (84 at defaults).
REQ-016 In SAMPLE, the 4 raw row values of column c are latched for debounce of keys 4c..4c+3.
REQ-017 Per key a counter of width ceil(log2(DB_N+1)): sample equal to keybits[k] -> counter = 0; sample differs -> counter + 1; when the increment reaches DB_N, keybits[k] toggles and counter = 0.
REQ-018 keybits[k] updates in the EMIT cycle for row k%4; an event {new keybits[k], k} is pushed in that same cycle.
REQ-019 Event FIFO: 4 entries, first-in first-out; pop when ev_valid && ev_ready; ev_code = head entry, undefined-free (0) when empty.
REQ-020 Push when full with no pop that cycle: event dropped, overflow set to 1, keybits still updates.
REQ-021 Push and pop same cycle when full: both occur, no overflow, count unchanged.
REQ-022 Push and pop same cycle when count is 1: new event becomes head next cycle, ev_valid stays 1.
REQ-023 overflow clears only on reset.
REQ-024 ev_ready ignored while ev_valid=0; ev_code/ev_valid change only on push/pop.

Reset
REQ-025 While reset=1 at a clock edge: col_oe=4'b0000, keybits=0, all debounce counters 0, FIFO empty, ev_valid=0, ev_code=0, overflow=0, synchronizer flops 1, c=0, FSM=SETTLE with cycle count 0.
REQ-026 First cycle after reset deassertion: col_oe=4'b0001; first SAMPLE occurs SETTLE_CYC cycles later.
REQ-027 Reset asserted mid-scan or with pending events aborts scan and discards all events; no partial event is emitted afterwards.

Verification (SETTLE_CYC=16, DB_N=3, ev_ready=1 unless stated)
REQ-028 Hold row_n[2]=0 whenever col_oe[1]=1 -> keybits[6]=1 and single event 0x16 during the third scan, in column-1 EMIT cycle for row 2; no other events.
REQ-029 Then release key 6 -> exactly one event 0x06 after 3 scans; keybits=0.
REQ-030 Press key 9 for 2 scans, release -> no event, keybits[9] never 1.
REQ-031 Press keys 4,5,6,7 together -> events 0x14,0x15,0x16,0x17 in that order on consecutive cycles.
REQ-032 ev_ready=0, press keys 0,1,2,3,8 -> ev_valid=1, 4 events queued (0x10..0x13), overflow=1, keybits=16'h010F; then ev_ready=1 drains 4 events and ev_valid falls.
REQ-033 Assert reset 1 cycle during column-2 SETTLE with 2 events queued -> next cycle all outputs at REQ-025 values, col_oe=4'b0001 after release.
